bus_1553_bc_sequencer: RTL and testbench

//  MIL-STD-1553 bus-controller message sequencer. Sits between the uP register file and the 1553 word encoder/decoder.

---
 rtl/bus_1553_bc_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_bus_1553_bc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_1553_bc_sequencer.sv
// MIL-STD-1553 bus-controller message sequencer: sends one command
// (+ data), waits for RT status, collects RT->BC data, reports status/err.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   s_msg_valid/ready/cmd          command descriptor handshake
//   s_data_tvalid/tready/tdata     BC->RT data words from the uP side
//   m_tx_tvalid/tready/tdata/tuser words to the encoder (01 cmd, 10 data)
//   s_rx_tvalid/tdata/tuser        decoder word strobe, no back-pressure
//   m_rdata_tvalid/tdata           RT->BC data word strobe
//   done, status, err, busy        message end pulse and held results
//
// Optional feature macro: BUS_1553_BC_RETRY_EN (buffer BC->RT data,
// retry the whole message once after the first error).
module bus_1553_bc_sequencer #(
  parameter int CLOCK_SPEED   = 100000000,
  parameter int RESP_TIMEOUT  = 2000,
  parameter int INTERWORD_MAX = 400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_msg_valid,
  output logic        s_msg_ready,
  input  logic [15:0] s_msg_cmd,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  input  logic [15:0] s_data_tdata,
  output logic        m_tx_tvalid,
  input  logic        m_tx_tready,
  output logic [15:0] m_tx_tdata,
  output logic [1:0]  m_tx_tuser,
  input  logic        s_rx_tvalid,
  input  logic [15:0] s_rx_tdata,
  input  logic [1:0]  s_rx_tuser,
  output logic        m_rdata_tvalid,
  output logic [15:0] m_rdata_tdata,
  output logic        done,
  output logic [15:0] status,
  output logic [1:0]  err,
  output logic        busy
);

  // Last waiting cycle in WAIT_STAT is RESP_TIMEOUT-1 after entry,
  // so done lands exactly RESP_TIMEOUT cycles after entry.
  localparam logic [15:0] LP_RESP_LIM =
    (CLOCK_SPEED > 0) ? 16'(RESP_TIMEOUT - 1) : 16'd0;
  localparam logic [15:0] LP_GAP_LIM = 16'(INTERWORD_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_SEND_DATA,
    S_WAIT_STAT, S_RECV_DATA, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cmd;
  logic [5:0]  r_wc;
  logic [5:0]  r_cnt;
  logic [15:0] r_timer;
  logic [15:0] r_stat_pend;
  logic [15:0] r_status;
  logic [1:0]  r_err;
  logic        r_rd_v;
  logic [15:0] r_rd_d;

  logic        w_fail;
  logic [1:0]  w_fcode;
  logic        w_stat_ok;
  logic        w_cnt_inc;
  logic        w_tx_v;
  logic [15:0] w_tx_d;
  logic [1:0]  w_tx_u;
  logic        w_d_rdy;
  logic        w_last;

`ifdef BUS_1553_BC_RETRY_EN
  logic [15:0] r_buf [32];
  logic        r_retried;
`endif

  assign w_last = (r_cnt == r_wc - 6'd1);

  always_comb begin
    w_next    = r_state;
    w_fail    = 1'b0;
    w_fcode   = 2'd0;
    w_stat_ok = 1'b0;
    w_cnt_inc = 1'b0;
    w_tx_v    = 1'b0;
    w_tx_d    = 16'h0000;
    w_tx_u    = 2'b00;
    w_d_rdy   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (s_msg_valid) w_next = S_SEND_CMD;
      end
      S_SEND_CMD: begin
        w_tx_v = 1'b1;
        w_tx_d = r_cmd;
        w_tx_u = 2'b01;
        if (m_tx_tready)
          w_next = r_cmd[10] ? S_WAIT_STAT : S_SEND_DATA;
      end
      S_SEND_DATA: begin
        w_tx_u = 2'b10;
`ifdef BUS_1553_BC_RETRY_EN
        if (r_retried) begin
          w_tx_v = 1'b1;
          w_tx_d = r_buf[r_cnt[4:0]];
        end else begin
          w_tx_v  = s_data_tvalid;
          w_tx_d  = s_data_tdata;
          w_d_rdy = m_tx_tready;
        end
`else
        w_tx_v  = s_data_tvalid;
        w_tx_d  = s_data_tdata;
        w_d_rdy = m_tx_tready;
`endif
        if (w_tx_v && m_tx_tready) begin
          w_cnt_inc = 1'b1;
          if (w_last) w_next = S_WAIT_STAT;
        end
      end
      S_WAIT_STAT: begin
        // An rx word in the expiry cycle wins over the timeout.
        if (s_rx_tvalid) begin
          if (s_rx_tuser != 2'b01) begin
            w_fail  = 1'b1;
            w_fcode = 2'd3;
          end else if (s_rx_tdata[15:11] != r_cmd[15:11]) begin
            w_fail  = 1'b1;
            w_fcode = 2'd2;
          end else begin
            w_stat_ok = 1'b1;
            w_next = r_cmd[10] ? S_RECV_DATA : S_DONE;
          end
        end else if (r_timer >= LP_RESP_LIM) begin
          w_fail  = 1'b1;
          w_fcode = 2'd1;
        end
      end
      S_RECV_DATA: begin
        if (s_rx_tvalid) begin
          if (s_rx_tuser != 2'b10) begin
            w_fail  = 1'b1;
            w_fcode = 2'd3;
          end else begin
            w_cnt_inc = 1'b1;
            if (w_last) w_next = S_DONE;
          end
        end else if (r_timer >= LP_GAP_LIM) begin
          w_fail  = 1'b1;
          w_fcode = 2'd1;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_fail) begin
`ifdef BUS_1553_BC_RETRY_EN
      w_next = r_retried ? S_DONE : S_SEND_CMD;
`else
      w_next = S_DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_wc        <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_stat_pend <= '0;
      r_status    <= '0;
      r_err       <= '0;
      r_rd_v      <= 1'b0;
      r_rd_d      <= '0;
`ifdef BUS_1553_BC_RETRY_EN
      r_retried   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && s_msg_valid) begin
        r_cmd       <= s_msg_cmd;
        r_wc        <= (s_msg_cmd[4:0] == 5'd0) ? 6'd32
                       : {1'b0, s_msg_cmd[4:0]};
        r_stat_pend <= '0;
`ifdef BUS_1553_BC_RETRY_EN
        r_retried   <= 1'b0;
`endif
      end
`ifdef BUS_1553_BC_RETRY_EN
      if (w_fail) r_retried <= 1'b1;
`endif
      if (w_next != r_state ||
          (r_state == S_RECV_DATA && s_rx_tvalid))
        r_timer <= '0;
      else if (r_timer != 16'hFFFF)
        r_timer <= r_timer + 16'd1;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_cnt_inc)
        r_cnt <= r_cnt + 6'd1;
      if (w_stat_ok) r_stat_pend <= s_rx_tdata;
      r_rd_v <= (r_state == S_RECV_DATA) && s_rx_tvalid &&
                (s_rx_tuser == 2'b10);
      if (s_rx_tvalid) r_rd_d <= s_rx_tdata;
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_status <= w_stat_ok ? s_rx_tdata : r_stat_pend;
        r_err    <= w_fail ? w_fcode : 2'd0;
      end
    end
  end

`ifdef BUS_1553_BC_RETRY_EN
  always_ff @(posedge clk) begin
    if (r_state == S_SEND_DATA && !r_retried &&
        s_data_tvalid && m_tx_tready)
      r_buf[r_cnt[4:0]] <= s_data_tdata;
  end
`endif

  assign s_msg_ready    = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign m_tx_tvalid    = w_tx_v;
  assign m_tx_tdata     = w_tx_d;
  assign m_tx_tuser     = w_tx_u;
  assign s_data_tready  = w_d_rdy;
  assign m_rdata_tvalid = r_rd_v;
  assign m_rdata_tdata  = r_rd_d;
  assign status         = r_status;
  assign err            = r_err;

endmodule

// File: tb/tb_bus_1553_bc_sequencer.sv
// Directed self-checking bench for bus_1553_bc_sequencer.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_bus_1553_bc_sequencer;

  localparam int RT = 100;
  localparam int IW = 40;

  logic        clk;
  logic        rstn;
  logic        s_msg_valid;
  logic        s_msg_ready;
  logic [15:0] s_msg_cmd;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [15:0] s_data_tdata;
  logic        m_tx_tvalid;
  logic        m_tx_tready;
  logic [15:0] m_tx_tdata;
  logic [1:0]  m_tx_tuser;
  logic        s_rx_tvalid;
  logic [15:0] s_rx_tdata;
  logic [1:0]  s_rx_tuser;
  logic        m_rdata_tvalid;
  logic [15:0] m_rdata_tdata;
  logic        done;
  logic [15:0] status;
  logic [1:0]  err;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t_cmd = 0;
  int t_done = 0;
  logic [17:0] tx_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] rd_exp [32];

  bus_1553_bc_sequencer #(
    .CLOCK_SPEED(100000000),
    .RESP_TIMEOUT(RT),
    .INTERWORD_MAX(IW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_msg_valid(s_msg_valid), .s_msg_ready(s_msg_ready),
    .s_msg_cmd(s_msg_cmd),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .s_data_tdata(s_data_tdata),
    .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tuser(m_tx_tuser),
    .s_rx_tvalid(s_rx_tvalid), .s_rx_tdata(s_rx_tdata),
    .s_rx_tuser(s_rx_tuser),
    .m_rdata_tvalid(m_rdata_tvalid), .m_rdata_tdata(m_rdata_tdata),
    .done(done), .status(status), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_tx_tvalid && m_tx_tready) begin
      tx_q.push_back({m_tx_tuser, m_tx_tdata});
      if (m_tx_tuser == 2'b01) t_cmd <= cyc;
    end
    if (m_rdata_tvalid) rd_q.push_back(m_rdata_tdata);
    if (done) begin
      done_cnt <= done_cnt + 1;
      t_done   <= cyc;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] txat(input int i);
    return (i < tx_q.size()) ? tx_q[i] : 18'h3FFFF;
  endfunction

  function automatic logic [15:0] rdat(input int i);
    return (i < rd_q.size()) ? rd_q[i] : 16'hDEAD;
  endfunction

  task automatic send_msg(input logic [15:0] c);
    @(posedge clk); #1;
    s_msg_valid = 1'b1;
    s_msg_cmd   = c;
    @(posedge clk); #1;
    s_msg_valid = 1'b0;
  endtask

  task automatic push_data(input logic [15:0] w);
    int k;
    s_data_tvalid = 1'b1;
    s_data_tdata  = w;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_data_tready && m_tx_tready) break;
    end
    chk("data_hs_in_time", 32'(k < 50), 32'd1);
    @(posedge clk); #1;
    s_data_tvalid = 1'b0;
  endtask

  task automatic rx_word(input logic [1:0] u, input logic [15:0] w);
    @(posedge clk); #1;
    s_rx_tvalid = 1'b1;
    s_rx_tuser  = u;
    s_rx_tdata  = w;
    @(posedge clk); #1;
    s_rx_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start;
    int k;
    start = done_cnt;
    for (k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (done_cnt != start) break;
    end
    chk("done_seen", 32'(done_cnt - start), 32'd1);
  endtask

  initial begin
    int bad;
    int d0;
    rstn = 1'b0;
    s_msg_valid = 1'b0;
    s_msg_cmd = '0;
    s_data_tvalid = 1'b0;
    s_data_tdata = '0;
    m_tx_tready = 1'b1;
    s_rx_tvalid = 1'b0;
    s_rx_tdata = '0;
    s_rx_tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_msg_ready), 32'd1);
    chk("rst_outs", {m_tx_tvalid, s_data_tready, m_rdata_tvalid,
                     done, busy, err}, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rstn = 1'b1;

    // stray rx word while idle is ignored
    rx_word(2'b01, 16'h0800);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rx_drop", {30'(done_cnt), busy, s_msg_ready}, 32'd1);

    // BC->RT, RT1 SA1 wc2
    tx_q.delete();
    send_msg(16'h0822);
    push_data(16'hAAAA);
    push_data(16'h5555);
    rx_word(2'b01, 16'h0800);
    wait_done(50);
    chk("bcrt_ntx", 32'(tx_q.size()), 32'd3);
    chk("bcrt_tx0", 32'(txat(0)), {14'd0, 2'b01, 16'h0822});
    chk("bcrt_tx1", 32'(txat(1)), {14'd0, 2'b10, 16'hAAAA});
    chk("bcrt_tx2", 32'(txat(2)), {14'd0, 2'b10, 16'h5555});
    chk("bcrt_err", 32'(err), 32'd0);
    chk("bcrt_status", 32'(status), 32'h0800);

    // RT->BC, wc 0 = 32 words
    tx_q.delete();
    rd_q.delete();
    for (int i = 0; i < 32; i++)
      rd_exp[i] = 16'(i * 273) ^ 16'hC3A5;
    send_msg(16'h0C20);
    rx_word(2'b01, 16'h0C00);
    for (int i = 0; i < 32; i++) rx_word(2'b10, rd_exp[i]);
    wait_done(50);
    chk("rtbc_ntx", 32'(tx_q.size()), 32'd1);
    chk("rtbc_nrd", 32'(rd_q.size()), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (rdat(i) !== rd_exp[i]) bad++;
    chk("rtbc_rd_order", 32'(bad), 32'd0);
    chk("rtbc_err", 32'(err), 32'd0);
    chk("rtbc_status", 32'(status), 32'h0C00);

`ifdef BUS_1553_BC_RETRY_EN
    // first status times out, whole message replayed from buffer
    tx_q.delete();
    send_msg(16'h0822);
    push_data(16'hAAAA);
    push_data(16'h5555);
    d0 = done_cnt;
    bad = 0;
    for (int k = 0; k < RT + 50; k++) begin
      @(negedge clk);
      if (s_data_tready) bad++;
      if (tx_q.size() >= 6) break;
    end
    chk("rty_no_data_ready", 32'(bad), 32'd0);
    chk("rty_no_early_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;
    rx_word(2'b01, 16'h0800);
    wait_done(50);
    chk("rty_ntx", 32'(tx_q.size()), 32'd6);
    chk("rty_tx3", 32'(txat(3)), {14'd0, 2'b01, 16'h0822});
    chk("rty_tx4", 32'(txat(4)), {14'd0, 2'b10, 16'hAAAA});
    chk("rty_tx5", 32'(txat(5)), {14'd0, 2'b10, 16'h5555});
    chk("rty_err", 32'(err), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("rty_done_once", 32'(done_cnt - d0), 32'd1);
`else
    // status-wait timeout, RT1 T wc1
    send_msg(16'h0C21);
    wait_done(RT + 50);
    chk("to_err", 32'(err), 32'd1);
    chk("to_latency", 32'(t_done - t_cmd), 32'(RT + 1));

    // status from wrong RT address
    send_msg(16'h0C21);
    rx_word(2'b01, 16'h1000);
    wait_done(50);
    chk("addr_err", 32'(err), 32'd2);

    // bad sync on a data word
    rd_q.delete();
    send_msg(16'h0C22);
    rx_word(2'b01, 16'h0C00);
    rx_word(2'b10, 16'h1234);
    rx_word(2'b00, 16'h5678);
    wait_done(50);
    chk("sync_err", 32'(err), 32'd3);
    chk("sync_nrd", 32'(rd_q.size()), 32'd1);
    chk("sync_rd0", 32'(rdat(0)), 32'h1234);

    // inter-word gap too long
    send_msg(16'h0C22);
    rx_word(2'b01, 16'h0C00);
    rx_word(2'b10, 16'h4321);
    wait_done(IW + 50);
    chk("gap_err", 32'(err), 32'd1);
`endif

    // encoder stall during command, then reset mid-RECV_DATA
    tx_q.delete();
    rd_q.delete();
    m_tx_tready = 1'b0;
    send_msg(16'h0C24);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(m_tx_tvalid === 1'b1 && m_tx_tdata === 16'h0C24 &&
            m_tx_tuser === 2'b01)) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_no_hs", 32'(tx_q.size()), 32'd0);
    @(posedge clk); #1;
    m_tx_tready = 1'b1;
    rx_word(2'b01, 16'h0C00);
    rx_word(2'b10, 16'hBEEF);
    d0 = done_cnt;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("mrst_ready", 32'(s_msg_ready), 32'd1);
    chk("mrst_outs", {m_tx_tvalid, s_data_tready, m_rdata_tvalid,
                      done, busy, err}, 32'd0);
    chk("mrst_data", {m_rdata_tdata, status}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mrst_rd", {16'(rd_q.size()), rdat(0)}, {16'd1, 16'hBEEF});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
